// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiply controller that borrows the shared
// EX-stage ALU (ADD) once per granted cycle to build the low WIDTH bits of a*b.
// Optional feature macro: MUL_EARLY_TERM_EN -- finish as soon as the remaining
// multiplier bits are all zero instead of always running WIDTH steps.
module alu_mul_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] OP_ADD  = 4'b0010,
  parameter logic [3:0] OP_IDLE = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             alu_req,
  input  logic             alu_grant,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int            CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    count_reg;
  logic             last_step;

  // The current granted step is the final one.
`ifdef MUL_EARLY_TERM_EN
  assign last_step = (count_reg == LAST_COUNT) || ((b_reg >> 1) == '0);
`else
  assign last_step = (count_reg == LAST_COUNT);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush outranks grant and ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && !flush) state_next = RUN;
      end
      RUN: begin
        if (flush)                      state_next = IDLE;
        else if (alu_grant && last_step) state_next = DONE;
      end
      DONE: begin
        if (flush || result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch and accumulate datapath; registers hold while ungranted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !flush) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            acc_reg   <= '0;
            count_reg <= '0;
          end
        end
        RUN: begin
          if (flush) begin
            acc_reg <= '0;
          end else if (alu_grant) begin
            acc_reg   <= alu_result;
            a_reg     <= a_reg << 1;
            b_reg     <= b_reg >> 1;
            count_reg <= count_reg + 1'b1;
          end
        end
        DONE: begin
          if (flush) acc_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; everything idles to zero outside RUN/DONE.
  always_comb begin
    busy         = 1'b0;
    alu_req      = 1'b0;
    alu_opcode   = OP_IDLE;
    alu_a        = '0;
    alu_b        = '0;
    result       = '0;
    result_valid = 1'b0;
    case (state_reg)
      RUN: begin
        busy       = 1'b1;
        alu_req    = 1'b1;
        alu_opcode = OP_ADD;
        alu_a      = acc_reg;
        alu_b      = b_reg[0] ? a_reg : '0;
      end
      DONE: begin
        busy         = 1'b1;
        result       = acc_reg;
        result_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer; the bench plays the role of the ALU.
module tb_alu_mul_sequencer;

  localparam int         WIDTH   = 32;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_IDLE = 4'b0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             alu_req;
  logic             alu_grant;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ready;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  // Shared ALU stand-in: ADD, carry dropped.
  assign alu_result = alu_a + alu_b;

  alu_mul_sequencer #(
    .WIDTH  (WIDTH),
    .OP_ADD (OP_ADD),
    .OP_IDLE(OP_IDLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .busy        (busy),
    .alu_req     (alu_req),
    .alu_grant   (alu_grant),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Number of granted steps a multiply should take for multiplier b.
  function automatic int exp_steps(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
`else
    return WIDTH;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a multiply and run it to DONE, tracking the accumulator with a model.
  // toggle=1 grants only every other RUN cycle, starting granted.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input bit toggle, input logic [31:0] exp);
    logic [31:0] m_acc, m_a, m_b;
    int cycles, run_idx, steps_done, exp_cyc;
    bit busy_ok;
    m_acc = '0; m_a = a; m_b = b;
    cycles = 0; run_idx = 0; steps_done = 0; busy_ok = 1'b1;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    step();
    start  = 1'b0;
    cycles = 1;
    while (!result_valid && cycles < 200) begin
      run_idx++;
      if (!busy || !alu_req || alu_opcode !== OP_ADD) busy_ok = 1'b0;
      check("acc_track", alu_a, m_acc);
      alu_grant = toggle ? run_idx[0] : 1'b1;
      if (alu_grant) begin
        m_acc = m_acc + (m_b[0] ? m_a : 32'd0);
        m_a   = m_a << 1;
        m_b   = m_b >> 1;
        steps_done++;
      end
      step();
      cycles++;
    end
    alu_grant = 1'b0;
    exp_cyc = toggle ? 2 * exp_steps(b) : exp_steps(b) + 1;
    check("latency", cycles, exp_cyc);
    check("busy_run", {31'd0, busy_ok}, 32'd1);
    check("steps", steps_done, exp_steps(b));
    check("valid", {31'd0, result_valid}, 32'd1);
    check("result", result, exp);
    $display("mul a=%h b=%h toggle=%0d -> result=%h cycles=%0d (expected %h, %0d)",
             a, b, toggle, result, cycles, exp, exp_cyc);
  endtask

  // Accept the result and confirm return to IDLE.
  task automatic accept();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, result_valid}, 32'd0);
    check("idle_result", result, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   {31'd0, busy},         32'd0);
    check({tag, "_req"},    {31'd0, alu_req},      32'd0);
    check({tag, "_opcode"}, {28'd0, alu_opcode},   {28'd0, OP_IDLE});
    check({tag, "_alu_a"},  alu_a,                 32'd0);
    check({tag, "_alu_b"},  alu_b,                 32'd0);
    check({tag, "_valid"},  {31'd0, result_valid}, 32'd0);
    check({tag, "_result"}, result,                32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; alu_grant = 1'b0;
    result_ready = 1'b0; op_a = '0; op_b = '0;
    #2;
    check_idle_outputs("reset");
    $display("reset state checked");
    step();
    step();
    reset = 1'b0;
    step();

    // 6*7 with continuous grant
    run_mul(32'd6, 32'd7, 1'b0, 32'd42);
    accept();

    // 6*7 with grant toggling; accumulator must hold on ungranted cycles
    run_mul(32'd6, 32'd7, 1'b1, 32'd42);
    accept();

    // wrap-around product
    run_mul(32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFE);
    accept();

    // back-pressure in DONE, a stray start is ignored
    run_mul(32'd6, 32'd7, 1'b0, 32'd42);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      check("hold_result", result, 32'd42);
      check("hold_valid", {31'd0, result_valid}, 32'd1);
    end
    start = 1'b0;
    // start coincident with ready must not be accepted
    op_a = 32'd1; op_b = 32'd1;
    result_ready = 1'b1;
    start = 1'b1;
    step();
    result_ready = 1'b0;
    start = 1'b0;
    check("ready_busy", {31'd0, busy}, 32'd0);
    check("ready_valid", {31'd0, result_valid}, 32'd0);
    step();
    check("no_queue_busy", {31'd0, busy}, 32'd0);
    $display("done back-pressure checked");

    // start together with flush in IDLE is not accepted
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", {31'd0, busy}, 32'd0);
    $display("start+flush in idle checked");

    // flush after 10 granted steps
    op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    alu_grant = 1'b1;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    alu_grant = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, result_valid}, 32'd0);
    check("flush_opcode", {28'd0, alu_opcode}, {28'd0, OP_IDLE});
    step();
    check("flush_valid2", {31'd0, result_valid}, 32'd0);
    $display("flush mid-run checked");
    run_mul(32'd3, 32'd5, 1'b0, 32'd15);
    accept();

    // asynchronous reset mid-run
    op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    alu_grant = 1'b1;
    repeat (5) step();
    #1 reset = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    $display("async reset mid-run checked");
    @(posedge clk);
    #1;
    reset = 1'b0;
    alu_grant = 1'b0;
    step();
    run_mul(32'd0, 32'd9, 1'b0, 32'd0);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
